multi_ctl: RTL and testbench

Multi-cycle main controller that sequences the existing datapath pieces (PC register, ALU plus ALU-control decoder, GPR, sign-extender, muxes) as a shared-resource multi-cycle CPU. The ALU computes PC increment, branch target and data results in successive cycles. A single instruction/data memory is accessed through a ready handshake. Sits between the instruction register opcode field and all datapath enables/selects, replacing the combinational single-cycle controller.

---
 rtl/multi_ctl_pkg.sv | 62 ++++++
 rtl/multi_ctl_dec.sv | 84 ++++++++
 rtl/multi_ctl.sv | 119 +++++++++++
 tb/tb_multi_ctl.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/multi_ctl_pkg.sv
// multi_ctl_pkg: shared definitions for the multi-cycle main controller.
//   - state encodings (4-bit state register)
//   - opcode constants for IR[31:26]
//   - ALUSrcB / ALUOp / PCSource encodings
//   - ctl_t: bundle of every datapath enable/select driven by the controller
// Optional feature macro: MULTI_CTL_ADDI_EN (adds the ADDIEX/ADDIWB states).
package multi_ctl_pkg;

    typedef enum logic [3:0] {
        ST_FETCH  = 4'd0,
        ST_DECODE = 4'd1,
        ST_MEMADR = 4'd2,
        ST_MEMRD  = 4'd3,
        ST_MEMWB  = 4'd4,
        ST_MEMWR  = 4'd5,
        ST_EXEC   = 4'd6,
        ST_RCOMP  = 4'd7,
        ST_BRANCH = 4'd8,
        ST_JUMP   = 4'd9
`ifdef MULTI_CTL_ADDI_EN
        ,
        ST_ADDIEX = 4'd10,
        ST_ADDIWB = 4'd11
`endif
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUB_REG = 2'b00;
    localparam logic [1:0] ALUB_ONE = 2'b01;
    localparam logic [1:0] ALUB_IMM = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctl_t;

endpackage

// File: rtl/multi_ctl_dec.sv
// multi_ctl_dec: combinational control-output decoder.
// Ports:
//   state    in   current controller state
//   mem_rdy  in   memory access completes this cycle
//   ctl      out  all datapath enables/selects for this cycle
// Optional feature macro: MULTI_CTL_ADDI_EN.
module multi_ctl_dec
    import multi_ctl_pkg::*;
(
    input  state_t state,
    input  logic   mem_rdy,
    output ctl_t   ctl
);

    always_comb begin
        ctl = '0;
        case (state)
            ST_FETCH: begin
                ctl.mem_read  = 1'b1;
                ctl.alu_src_b = ALUB_ONE;
                ctl.alu_op    = ALUOP_ADD;
                ctl.pc_source = PCS_ALU;
                // IR load and PC+1 only on the completing cycle so the PC
                // advances exactly once however long the fetch stalls.
                ctl.ir_write  = mem_rdy;
                ctl.pc_write  = mem_rdy;
            end
            ST_DECODE: begin
                // Speculative branch target PC+1+sext(imm) into ALUOut.
                ctl.alu_src_b = ALUB_IMM;
                ctl.alu_op    = ALUOP_ADD;
            end
            ST_MEMADR: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = ALUB_IMM;
                ctl.alu_op    = ALUOP_ADD;
            end
            ST_MEMRD: begin
                ctl.mem_read = 1'b1;
                ctl.iord     = 1'b1;
            end
            ST_MEMWB: begin
                ctl.reg_write  = 1'b1;
                ctl.mem_to_reg = 1'b1;
            end
            ST_MEMWR: begin
                ctl.mem_write = 1'b1;
                ctl.iord      = 1'b1;
            end
            ST_EXEC: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = ALUB_REG;
                ctl.alu_op    = ALUOP_FUNCT;
            end
            ST_RCOMP: begin
                ctl.reg_write = 1'b1;
                ctl.reg_dst   = 1'b1;
            end
            ST_BRANCH: begin
                ctl.alu_src_a     = 1'b1;
                ctl.alu_src_b     = ALUB_REG;
                ctl.alu_op        = ALUOP_SUB;
                ctl.pc_write_cond = 1'b1;
                ctl.pc_source     = PCS_ALUOUT;
            end
            ST_JUMP: begin
                ctl.pc_write  = 1'b1;
                ctl.pc_source = PCS_JUMP;
            end
`ifdef MULTI_CTL_ADDI_EN
            ST_ADDIEX: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = ALUB_IMM;
                ctl.alu_op    = ALUOP_ADD;
            end
            ST_ADDIWB: begin
                ctl.reg_write = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/multi_ctl.sv
// multi_ctl: multi-cycle main controller for the shared-ALU CPU datapath.
// Holds the state register, next-state logic and retired-instruction counter;
// output decoding lives in multi_ctl_dec.
// Ports:
//   clk, rst            clock (rising edge), async active-high reset
//   i_op                opcode IR[31:26]
//   i_zf                ALU zero flag (branch gating is done in the datapath)
//   i_mem_rdy           memory access completes this cycle
//   o_pc_write ..       datapath enables/selects (all 0 while rst=1)
//   o_state             current state (debug)
//   o_icnt              retired instruction count, wraps mod 2^CNT_W
// Optional feature macro: MULTI_CTL_ADDI_EN (addi via ADDIEX/ADDIWB).
module multi_ctl
    import multi_ctl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       i_op,
    input  logic             i_zf,
    input  logic             i_mem_rdy,
    output logic             o_pc_write,
    output logic             o_pc_write_cond,
    output logic             o_iord,
    output logic             o_mem_read,
    output logic             o_mem_write,
    output logic             o_ir_write,
    output logic             o_mem_to_reg,
    output logic             o_reg_dst,
    output logic             o_reg_write,
    output logic             o_alu_src_a,
    output logic [1:0]       o_alu_src_b,
    output logic [1:0]       o_alu_op,
    output logic [1:0]       o_pc_source,
    output logic [3:0]       o_state,
    output logic [CNT_W-1:0] o_icnt
);

    state_t           state, next_state;
    ctl_t             ctl, ctl_gated;
    logic [CNT_W-1:0] icnt;

    // The zero flag only qualifies pc_write_cond inside the datapath.
    logic zf_unused;
    assign zf_unused = i_zf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_FETCH;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_FETCH:  next_state = i_mem_rdy ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                case (i_op)
                    OP_RTYPE:     next_state = ST_EXEC;
                    OP_LW, OP_SW: next_state = ST_MEMADR;
                    OP_BEQ:       next_state = ST_BRANCH;
                    OP_J:         next_state = ST_JUMP;
`ifdef MULTI_CTL_ADDI_EN
                    OP_ADDI:      next_state = ST_ADDIEX;
`endif
                    // Unknown opcodes retire as NOPs.
                    default:      next_state = ST_FETCH;
                endcase
            end
            ST_MEMADR: next_state = (i_op == OP_LW) ? ST_MEMRD : ST_MEMWR;
            ST_MEMRD:  next_state = i_mem_rdy ? ST_MEMWB : ST_MEMRD;
            ST_MEMWB:  next_state = ST_FETCH;
            ST_MEMWR:  next_state = i_mem_rdy ? ST_FETCH : ST_MEMWR;
            ST_EXEC:   next_state = ST_RCOMP;
            ST_RCOMP:  next_state = ST_FETCH;
            ST_BRANCH: next_state = ST_FETCH;
            ST_JUMP:   next_state = ST_FETCH;
`ifdef MULTI_CTL_ADDI_EN
            ST_ADDIEX: next_state = ST_ADDIWB;
            ST_ADDIWB: next_state = ST_FETCH;
`endif
            default:   next_state = ST_FETCH;
        endcase
    end

    // An instruction retires whenever control returns to FETCH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            icnt <= '0;
        else if (next_state == ST_FETCH && state != ST_FETCH)
            icnt <= icnt + 1'b1;
    end

    multi_ctl_dec u_dec (
        .state   (state),
        .mem_rdy (i_mem_rdy),
        .ctl     (ctl)
    );

    // FETCH decodes to active strobes, so reset must mask them explicitly.
    assign ctl_gated = rst ? '0 : ctl;

    assign o_pc_write      = ctl_gated.pc_write;
    assign o_pc_write_cond = ctl_gated.pc_write_cond;
    assign o_iord          = ctl_gated.iord;
    assign o_mem_read      = ctl_gated.mem_read;
    assign o_mem_write     = ctl_gated.mem_write;
    assign o_ir_write      = ctl_gated.ir_write;
    assign o_mem_to_reg    = ctl_gated.mem_to_reg;
    assign o_reg_dst       = ctl_gated.reg_dst;
    assign o_reg_write     = ctl_gated.reg_write;
    assign o_alu_src_a     = ctl_gated.alu_src_a;
    assign o_alu_src_b     = ctl_gated.alu_src_b;
    assign o_alu_op        = ctl_gated.alu_op;
    assign o_pc_source     = ctl_gated.pc_source;
    assign o_state         = rst ? 4'd0 : state;
    assign o_icnt          = icnt;

endmodule

// File: tb/tb_multi_ctl.sv
// tb_multi_ctl: directed self-checking bench for multi_ctl.
// A small counter width is used so retired-count wraparound is reached.
module tb_multi_ctl;

    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [5:0]    i_op;
    logic          i_zf;
    logic          i_mem_rdy;
    logic          pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic          mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0]    alu_src_b, alu_op, pc_source;
    logic [3:0]    state;
    logic [CW-1:0] icnt;

    int errors = 0;
    int checks = 0;
    bit [CW-1:0] exp_icnt = '0;

    always #5 clk = ~clk;

    multi_ctl #(.CNT_W(CW)) dut (
        .clk             (clk),
        .rst             (rst),
        .i_op            (i_op),
        .i_zf            (i_zf),
        .i_mem_rdy       (i_mem_rdy),
        .o_pc_write      (pc_write),
        .o_pc_write_cond (pc_write_cond),
        .o_iord          (iord),
        .o_mem_read      (mem_read),
        .o_mem_write     (mem_write),
        .o_ir_write      (ir_write),
        .o_mem_to_reg    (mem_to_reg),
        .o_reg_dst       (reg_dst),
        .o_reg_write     (reg_write),
        .o_alu_src_a     (alu_src_a),
        .o_alu_src_b     (alu_src_b),
        .o_alu_op        (alu_op),
        .o_pc_source     (pc_source),
        .o_state         (state),
        .o_icnt          (icnt)
    );

    // {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
    //  mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source}
    logic [15:0] ctl_vec;
    assign ctl_vec = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                      mem_to_reg, reg_dst, reg_write, alu_src_a,
                      alu_src_b, alu_op, pc_source};

    // Hand-written expected control word per state.
    function automatic logic [15:0] exp_ctl(int st, bit rdy);
        case (st)
            0:  exp_ctl = rdy ? 16'b1_0_0_1_0_1_0_0_0_0_01_00_00
                              : 16'b0_0_0_1_0_0_0_0_0_0_01_00_00;
            1:  exp_ctl = 16'b0_0_0_0_0_0_0_0_0_0_10_00_00;
            2:  exp_ctl = 16'b0_0_0_0_0_0_0_0_0_1_10_00_00;
            3:  exp_ctl = 16'b0_0_1_1_0_0_0_0_0_0_00_00_00;
            4:  exp_ctl = 16'b0_0_0_0_0_0_1_0_1_0_00_00_00;
            5:  exp_ctl = 16'b0_0_1_0_1_0_0_0_0_0_00_00_00;
            6:  exp_ctl = 16'b0_0_0_0_0_0_0_0_0_1_00_10_00;
            7:  exp_ctl = 16'b0_0_0_0_0_0_0_1_1_0_00_00_00;
            8:  exp_ctl = 16'b0_1_0_0_0_0_0_0_0_1_00_01_01;
            9:  exp_ctl = 16'b1_0_0_0_0_0_0_0_0_0_00_00_10;
            10: exp_ctl = 16'b0_0_0_0_0_0_0_0_0_1_10_00_00;
            11: exp_ctl = 16'b0_0_0_0_0_0_0_0_1_0_00_00_00;
            default: exp_ctl = 16'h0000;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Called at a falling edge: drive rdy, check state and controls, advance.
    task automatic cyc(input string tag, input int st, input bit rdy);
        i_mem_rdy = rdy;
        #1;
        chk({tag, " state"}, {28'd0, state}, st);
        chk({tag, " ctl"}, {16'd0, ctl_vec}, {16'd0, exp_ctl(st, rdy)});
        @(negedge clk);
    endtask

    task automatic retired(input string tag);
        exp_icnt = exp_icnt + 1'b1;
        #1;
        chk({tag, " icnt"}, {29'd0, icnt}, {29'd0, exp_icnt});
        chk({tag, " back in fetch"}, {28'd0, state}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; i_op = 6'b0; i_zf = 1'b0; i_mem_rdy = 1'b1;
        #2;
        chk("reset ctl", {16'd0, ctl_vec}, 32'd0);
        chk("reset state", {28'd0, state}, 32'd0);
        chk("reset icnt", {29'd0, icnt}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // R-type, no waits
        i_op = 6'b000000;
        cyc("R f", 0, 1); cyc("R d", 1, 1); cyc("R ex", 6, 1); cyc("R rc", 7, 1);
        retired("R");

        // lw, two wait cycles in MEMRD
        i_op = 6'b100011;
        cyc("lw f", 0, 1); cyc("lw d", 1, 1); cyc("lw ma", 2, 1);
        cyc("lw rd0", 3, 0); cyc("lw rd1", 3, 0); cyc("lw rd2", 3, 1);
        cyc("lw wb", 4, 1);
        retired("lw");

        // sw, three wait cycles in FETCH
        i_op = 6'b101011;
        cyc("sw f0", 0, 0); cyc("sw f1", 0, 0); cyc("sw f2", 0, 0); cyc("sw f3", 0, 1);
        cyc("sw d", 1, 1); cyc("sw ma", 2, 1); cyc("sw wr", 5, 1);
        retired("sw");

        // beq, taken and not taken: controller outputs identical
        i_op = 6'b000100; i_zf = 1'b1;
        cyc("beq1 f", 0, 1); cyc("beq1 d", 1, 1); cyc("beq1 br", 8, 1);
        retired("beq1");
        i_zf = 1'b0;
        cyc("beq0 f", 0, 1); cyc("beq0 d", 1, 1); cyc("beq0 br", 8, 1);
        retired("beq0");

        // j
        i_op = 6'b000010;
        cyc("j f", 0, 1); cyc("j d", 1, 1); cyc("j jp", 9, 1);
        retired("j");

        // unknown opcode retires as NOP
        i_op = 6'b111111;
        cyc("nop f", 0, 1); cyc("nop d", 1, 1);
        retired("nop");

        // addi: the counter wraps to 0 on this retirement
        i_op = 6'b001000;
        cyc("addi f", 0, 1); cyc("addi d", 1, 1);
`ifdef MULTI_CTL_ADDI_EN
        cyc("addi ex", 10, 1); cyc("addi wb", 11, 1);
`endif
        retired("addi");

        // async reset in MEMRD of an lw
        i_op = 6'b100011;
        cyc("rlw f", 0, 1); cyc("rlw d", 1, 1); cyc("rlw ma", 2, 1);
        i_mem_rdy = 1'b0;
        #1;
        chk("rlw memrd state", {28'd0, state}, 32'd3);
        #2;
        rst = 1'b1;
        #1;
        chk("mid rst ctl", {16'd0, ctl_vec}, 32'd0);
        chk("mid rst state", {28'd0, state}, 32'd0);
        chk("mid rst icnt", {29'd0, icnt}, 32'd0);
        exp_icnt = '0;
        @(negedge clk);
        rst = 1'b0;
        cyc("lw2 f", 0, 1); cyc("lw2 d", 1, 1); cyc("lw2 ma", 2, 1);
        cyc("lw2 rd", 3, 1); cyc("lw2 wb", 4, 1);
        retired("lw2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
